// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: RV32I width codes, FSM states
// and the per-width byte mask.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] width_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Unsigned widths only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
         (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Combinational lane/data alignment: byte-lane mask across two words, store data
// shift and load data shift with sign/zero extension.
module lsu_mem_master_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [7:0]  o_lanes8,
  output logic [63:0] o_w64,
  output logic [31:0] o_rdata
);

  logic [31:0] w_r32;

  assign o_lanes8 = {4'b0000, width_mask(i_funct3)} << i_off;
  assign o_w64    = {32'b0, i_wdata} << {i_off, 3'b000};
  assign w_r32    = 32'({i_hi, i_lo} >> {i_off, 3'b000});

  always_comb begin
    o_rdata = w_r32;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_r32[7]}}, w_r32[7:0]};
      F3_H:    o_rdata = {{16{w_r32[15]}}, w_r32[15:0]};
      F3_BU:   o_rdata = {24'b0, w_r32[7:0]};
      F3_HU:   o_rdata = {16'b0, w_r32[15:0]};
      default: o_rdata = w_r32;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one RV32I access per handshake, split into two RAM cycles
// when it crosses a word boundary; drives the shared data bus only while writing.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wen,
  output logic [3:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output lsu_state_e        dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a single-cycle pulse that the
  // core must take (no backpressure).

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;
  logic              r_err;

  logic [7:0]        w_lanes8;
  logic [63:0]       w_w64;
  logic [31:0]       w_rdata;
  logic [31:0]       w_wr_word;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;

  lsu_mem_master_align u_align (
    .i_funct3 (r_f3),
    .i_off    (r_addr[1:0]),
    .i_wdata  (r_wdata),
    .i_lo     (r_lo),
    .i_hi     (r_hi),
    .o_lanes8 (w_lanes8),
    .o_w64    (w_w64),
    .o_rdata  (w_rdata)
  );

  assign w_word0   = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_word1   = w_word0 + ADDR_W'(4);
  assign dbg_state = r_state;
  assign mem_data  = mem_wen ? w_wr_word : {DATA_W{1'bz}};

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'b0;
    resp_err    = 1'b0;
    mem_wen     = 1'b0;
    mem_byte_en = 4'b0000;
    mem_addr    = '0;
    w_wr_word   = 32'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = f3_legal(req_funct3, req_we) ? ST_ACC0 : ST_RESP;
        end
      end
      ST_ACC0: begin
        mem_addr    = w_word0;
        mem_byte_en = w_lanes8[3:0];
        mem_wen     = r_we;
        w_wr_word   = w_w64[31:0];
        w_next      = (w_lanes8[7:4] != 4'b0000) ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        mem_addr    = w_word1;
        mem_byte_en = w_lanes8[7:4];
        mem_wen     = r_we;
        w_wr_word   = w_w64[63:32];
        w_next      = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_we || r_err) ? 32'b0 : w_rdata;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'b0;
      r_lo    <= 32'b0;
      r_hi    <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && req_valid) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= !f3_legal(req_funct3, req_we);
        // hi stays zero when the access fits in one word
        r_lo    <= 32'b0;
        r_hi    <= 32'b0;
      end
      if (r_state == ST_ACC0 && !r_we) r_lo <= mem_data[31:0];
      if (r_state == ST_ACC1 && !r_we) r_hi <= mem_data[31:0];
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-addressed reference memory model, directed
// scenarios from the block's plan, randomized traffic and reset abort.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wen;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  lsu_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  lsu_mem_master dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wen     (mem_wen),
    .mem_byte_en (mem_byte_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  // 64-word RAM, indexed by address bits [7:2]; reads are combinational.
  logic [31:0] ram     [64];
  logic [31:0] ref_mem [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  assign mem_data = (!mem_wen && mem_byte_en != 4'b0000) ? ram[mem_addr[7:2]] : 32'bz;

  always @(posedge clk) begin
    if (ld_en) begin
      ram[ld_idx] <= ld_val;
    end else if (mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (mem_byte_en[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input logic we, input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (!we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ba;
    v = 32'b0;
    for (int i = 0; i < ref_size(f3); i++) begin
      ba = a + 32'(i);
      v[8*i +: 8] = ref_mem[ba[7:2]][8*ba[1:0] +: 8];
    end
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // ---------------- driver ----------------
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be   [2];
  int          obs_n;
  int          obs_lat;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_wen_any;

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    bit          ok;
    bit          done;
    int          exp_n;
    int          exp_lat;
    logic [31:0] ba;
    logic [31:0] w0;
    logic [3:0]  exp_be [2];
    logic [31:0] exp_rd;
    ok = ref_legal(we, f3);
    w0 = a & 32'hFFFF_FFFC;
    exp_be[0] = 4'b0; exp_be[1] = 4'b0; exp_n = 0;
    if (ok) begin
      exp_n = 1;
      for (int i = 0; i < ref_size(f3); i++) begin
        ba = a + 32'(i);
        if ((ba & 32'hFFFF_FFFC) == w0) exp_be[0][ba[1:0]] = 1'b1;
        else begin exp_be[1][ba[1:0]] = 1'b1; exp_n = 2; end
      end
    end
    exp_lat = ok ? exp_n + 1 : 1;
    exp_q.push_back((ok && !we) ? ref_load(f3, a) : 32'b0);
    if (ok && we) begin
      for (int i = 0; i < ref_size(f3); i++) begin
        ba = a + 32'(i);
        ref_mem[ba[7:2]][8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: got %b expected 1", req_ready);
    end
    obs_n = 0; obs_lat = 0; obs_rdata = 32'b0; obs_err = 1'b0; obs_wen_any = 1'b0; done = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_wen) obs_wen_any = 1'b1;
      if (resp_valid) begin
        done = 1'b1; obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
      end else if (mem_byte_en != 4'b0000) begin
        if (obs_n < 2) begin obs_addr[obs_n] = mem_addr; obs_be[obs_n] = mem_byte_en; end
        obs_n++;
        n_checks++;
        if (mem_wen !== we) begin
          n_fail++; $display("FAIL mem_wen: got %b expected %b", mem_wen, we);
        end
      end
      n_checks++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready: got %b expected 0 (cycle %0d)", req_ready, c);
      end
    end

    n_checks++;
    if (!done) begin n_fail++; $display("FAIL resp_timeout: no resp_valid within 8 cycles"); end
    n_checks++;
    if (obs_lat != exp_lat) begin
      n_fail++; $display("FAIL latency: got %0d expected %0d (f3=%0d addr=%h)", obs_lat, exp_lat, f3, a);
    end
    n_checks++;
    if (obs_err !== !ok) begin
      n_fail++; $display("FAIL resp_err: got %b expected %b", obs_err, !ok);
    end
    exp_rd = exp_q.pop_front();
    n_checks++;
    if (obs_rdata !== exp_rd) begin
      n_fail++; $display("FAIL resp_rdata: got %h expected %h (f3=%0d addr=%h)", obs_rdata, exp_rd, f3, a);
    end
    n_checks++;
    if (obs_n != exp_n) begin
      n_fail++; $display("FAIL access_count: got %0d expected %0d (addr=%h)", obs_n, exp_n, a);
    end
    for (int k = 0; k < exp_n && k < obs_n; k++) begin
      n_checks++;
      if (obs_addr[k] !== w0 + 32'(4 * k)) begin
        n_fail++; $display("FAIL mem_addr%0d: got %h expected %h", k, obs_addr[k], w0 + 32'(4 * k));
      end
      n_checks++;
      if (obs_be[k] !== exp_be[k]) begin
        n_fail++; $display("FAIL byte_en%0d: got %b expected %b (addr=%h)", k, obs_be[k], exp_be[k], a);
      end
    end
    if (!ok) begin
      n_checks++;
      if (obs_wen_any !== 1'b0) begin n_fail++; $display("FAIL illegal_wen: got 1 expected 0"); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_resp: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'b0 || resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0",
                         req_ready, resp_valid, resp_rdata, resp_err);
    end
    n_checks++;
    if (mem_wen !== 1'b0 || mem_byte_en !== 4'b0 || mem_addr !== 32'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_mem: got wen=%b be=%b addr=%h state=%0d expected 0 0 0 IDLE",
                         mem_wen, mem_byte_en, mem_addr, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_aligned_load;
    do_txn(1'b0, 3'b010, 32'h10, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h8899AABB || obs_lat != 2 || obs_be[0] !== 4'b1111) begin
      n_fail++; $display("FAIL lw_0x10: got rdata=%h lat=%0d be=%b expected 8899aabb 2 1111",
                         obs_rdata, obs_lat, obs_be[0]);
    end
  endtask

  task automatic test_byte_loads;
    do_txn(1'b0, 3'b000, 32'h13, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'hFFFFFF88 || obs_be[0] !== 4'b1000) begin
      n_fail++; $display("FAIL lb_0x13: got %h be=%b expected ffffff88 1000", obs_rdata, obs_be[0]);
    end
    do_txn(1'b0, 3'b100, 32'h13, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h00000088) begin
      n_fail++; $display("FAIL lbu_0x13: got %h expected 00000088", obs_rdata);
    end
  endtask

  task automatic test_crossing_load;
    do_txn(1'b0, 3'b101, 32'h13, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h00004488 || obs_lat != 3 || obs_n != 2 ||
        obs_be[0] !== 4'b1000 || obs_be[1] !== 4'b0001 ||
        obs_addr[0] !== 32'h10 || obs_addr[1] !== 32'h14) begin
      n_fail++; $display("FAIL lhu_0x13: got rdata=%h lat=%0d n=%0d expected 00004488 3 2",
                         obs_rdata, obs_lat, obs_n);
    end
  endtask

  task automatic test_split_store;
    do_txn(1'b1, 3'b010, 32'h12, 32'hDEADBEEF);
    n_checks++;
    if (ram[4] !== 32'hBEEFAABB || ram[5] !== 32'h1122DEAD) begin
      n_fail++; $display("FAIL sw_0x12_ram: got %h %h expected beefaabb 1122dead", ram[4], ram[5]);
    end
    n_checks++;
    if (obs_be[0] !== 4'b1100 || obs_be[1] !== 4'b0011 || obs_rdata !== 32'b0) begin
      n_fail++; $display("FAIL sw_0x12_bus: got be=%b/%b rdata=%h expected 1100/0011 0",
                         obs_be[0], obs_be[1], obs_rdata);
    end
  endtask

  task automatic test_illegal;
    do_txn(1'b0, 3'b011, 32'h10, 32'h0);
    n_checks++;
    if (obs_lat != 1 || obs_err !== 1'b1 || obs_n != 0 || obs_wen_any !== 1'b0) begin
      n_fail++; $display("FAIL f3_011: got lat=%0d err=%b n=%0d wen=%b expected 1 1 0 0",
                         obs_lat, obs_err, obs_n, obs_wen_any);
    end
    do_txn(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    n_checks++;
    if (obs_err !== 1'b1 || ram[4] !== 32'hBEEFAABB) begin
      n_fail++; $display("FAIL sbu_illegal: got err=%b word=%h expected 1 beefaabb", obs_err, ram[4]);
    end
  endtask

  task automatic test_wrap_store;
    do_txn(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);
    n_checks++;
    if (obs_addr[0] !== 32'hFFFFFFFC || obs_addr[1] !== 32'h0 || obs_n != 2) begin
      n_fail++; $display("FAIL wrap_addr: got %h then %h expected fffffffc then 0", obs_addr[0], obs_addr[1]);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (dbg_state !== ST_ACC0) begin
      n_fail++; $display("FAIL rst_pre_state: got %0d expected ACC0", dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_mid_acc: got valid=%b ready=%b state=%0d expected 0 1 IDLE",
                         resp_valid, req_ready, dbg_state);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_resp: got resp_valid=1 expected 0 (cycle %0d)", c);
      end
    end
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(we, f3, a, $urandom);
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (ram[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL ram_word%0d: got %h expected %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'b0; req_wdata = 32'b0; ld_en = 1'b0; ld_idx = 6'd0; ld_val = 32'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'b0;
    test_reset();
    for (int i = 0; i < 64; i++) preload(6'(i), 32'b0);
    preload(6'd4, 32'h8899AABB);
    preload(6'd5, 32'h11223344);
    test_aligned_load();
    test_byte_loads();
    test_crossing_load();
    test_split_store();
    test_illegal();
    test_wrap_store();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
